// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants, AXI field defaults and FSM state types for the sram-to-AXI bridge.
package sram_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [ID_W-1:0] INST_ID_DEF = 4'd0;
  localparam logic [ID_W-1:0] DATA_ID_DEF = 4'd1;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;
  localparam logic [3:0] CACHE_NONE = 4'd0;
  localparam logic [2:0] PROT_NONE  = 3'd0;
  localparam logic [1:0] LOCK_NONE  = 2'd0;

  typedef enum logic {
    AR_IDLE,
    AR_REQ
  } ar_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_RESP
  } w_state_t;

  // sram size encodes bytes as log2, which maps directly onto AXI AxSIZE
  function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_axi_wr_channel.sv
// Single-beat AXI write engine: issues AW and W independently, then waits for B.
module axi_wr_channel
  import sram_axi_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              awready,
  input  logic              wready,
  input  logic              bvalid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  output logic              idle
);

  w_state_t state;

  logic aw_done_c;
  logic w_done_c;

  // A channel counts as done once its valid has dropped or is handshaking now
  assign aw_done_c = !awvalid || awready;
  assign w_done_c  = !wvalid  || wready;
  assign idle      = (state == W_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= W_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= '0;
      awsize  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
    end else begin
      case (state)
        W_IDLE: begin
          if (accept) begin
            awaddr  <= req_addr;
            awsize  <= axi_size(req_size);
            wdata   <= req_wdata;
            wstrb   <= req_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= W_SEND;
          end
        end
        W_SEND: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (aw_done_c && w_done_c) state <= W_RESP;
        end
        W_RESP: begin
          if (bvalid) state <= W_IDLE;
        end
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst and data sram-like ports onto one AXI3 master.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [ID_W-1:0] INST_ID = INST_ID_DEF,
  parameter logic [ID_W-1:0] DATA_ID = DATA_ID_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [1:0]        inst_sram_size,
  input  logic [STRB_W-1:0] inst_sram_wstrb,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [DATA_W-1:0] inst_sram_rdata,

  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [STRB_W-1:0] data_sram_wstrb,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata,

  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,

  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,

  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,

  output logic [ID_W-1:0]   wid,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,

  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  ar_state_t ar_state;

  logic inst_pend;
  logic data_pend;
  logic wr_idle;

  logic data_rd_go_c;
  logic inst_rd_go_c;
  logic data_wr_go_c;
  logic rd_open_c;
  logic r_inst_c;
  logic r_data_c;
  logic b_hs_c;

  assign arlen   = LEN_SINGLE;
  assign arburst = BURST_INCR;
  assign arlock  = LOCK_NONE;
  assign arcache = CACHE_NONE;
  assign arprot  = PROT_NONE;
  assign awlen   = LEN_SINGLE;
  assign awburst = BURST_INCR;
  assign awlock  = LOCK_NONE;
  assign awcache = CACHE_NONE;
  assign awprot  = PROT_NONE;
  assign awid    = DATA_ID;
  assign wid     = DATA_ID;
  assign wlast   = 1'b1;
  assign rready  = 1'b1;
  assign bready  = 1'b1;

  // Reads wait for any in-flight store so a later fetch or load sees its data
  assign rd_open_c    = !reset && (ar_state == AR_IDLE) && wr_idle;
  assign data_rd_go_c = rd_open_c && data_sram_req && !data_sram_wr && !data_pend;
  assign inst_rd_go_c = rd_open_c && inst_sram_req && !inst_pend && !data_rd_go_c;
  assign data_wr_go_c = !reset && wr_idle && data_sram_req && data_sram_wr &&
                        !data_pend && !data_rd_go_c;

  assign inst_sram_addr_ok = inst_rd_go_c;
  assign data_sram_addr_ok = data_rd_go_c || data_wr_go_c;

  assign r_inst_c = rvalid && rready && (rid == INST_ID);
  assign r_data_c = rvalid && rready && (rid == DATA_ID);
  assign b_hs_c   = bvalid && bready;

  // Read address channel: latch the winner, hold AR until the slave takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state <= AR_IDLE;
      arvalid  <= 1'b0;
      arid     <= '0;
      araddr   <= '0;
      arsize   <= '0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (data_rd_go_c) begin
            arid     <= DATA_ID;
            araddr   <= data_sram_addr;
            arsize   <= axi_size(data_sram_size);
            arvalid  <= 1'b1;
            ar_state <= AR_REQ;
          end else if (inst_rd_go_c) begin
            arid     <= INST_ID;
            araddr   <= inst_sram_addr;
            arsize   <= axi_size(inst_sram_size);
            arvalid  <= 1'b1;
            ar_state <= AR_REQ;
          end
        end
        AR_REQ: begin
          if (arready) begin
            arvalid  <= 1'b0;
            ar_state <= AR_IDLE;
          end
        end
      endcase
    end
  end

  // Outstanding tracking and registered completion toward the core
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_pend         <= 1'b0;
      data_pend         <= 1'b0;
      inst_sram_data_ok <= 1'b0;
      data_sram_data_ok <= 1'b0;
      inst_sram_rdata   <= '0;
      data_sram_rdata   <= '0;
    end else begin
      inst_pend         <= inst_rd_go_c || (inst_pend && !r_inst_c);
      data_pend         <= data_rd_go_c || data_wr_go_c ||
                           (data_pend && !(r_data_c || b_hs_c));
      inst_sram_data_ok <= r_inst_c;
      data_sram_data_ok <= r_data_c || b_hs_c;
      if (r_inst_c) inst_sram_rdata <= rdata;
      if (r_data_c) data_sram_rdata <= rdata;
    end
  end

  axi_wr_channel u_wr (
    .clk       (clk),
    .reset     (reset),
    .accept    (data_wr_go_c),
    .req_addr  (data_sram_addr),
    .req_size  (data_sram_size),
    .req_wstrb (data_sram_wstrb),
    .req_wdata (data_sram_wdata),
    .awready   (awready),
    .wready    (wready),
    .bvalid    (b_hs_c),
    .awaddr    (awaddr),
    .awsize    (awsize),
    .awvalid   (awvalid),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .idle      (wr_idle)
  );

  // Inst port never writes; response codes and rlast carry no information here
  logic unused_ok;
  assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                       rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: directed scenarios plus random core/slave traffic vs a transaction model.
module tb_sram_axi_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: what is in flight and what must appear next cycle
  bit          m_ar_v, m_wr_busy, m_aw_v, m_w_v;
  bit          m_inst_out, m_data_out, m_inst_ok, m_data_ok;
  logic [31:0] m_araddr, m_awaddr, m_wdata, m_inst_rd, m_data_rd;
  logic [3:0]  m_arid, m_wstrb;
  logic [2:0]  m_arsize, m_awsize;

  always @(negedge clk) begin
    bit e_drd, e_ird, e_dwr, r_i, r_d;
    e_drd = !reset && !m_ar_v && !m_wr_busy && data_sram_req && !data_sram_wr && !m_data_out;
    e_ird = !reset && !m_ar_v && !m_wr_busy && inst_sram_req && !m_inst_out && !e_drd;
    e_dwr = !reset && !m_wr_busy && data_sram_req && data_sram_wr && !m_data_out;
    r_i   = rvalid && (rid == 4'd0);
    r_d   = rvalid && (rid == 4'd1);
    if (chk_en) begin
      chk("m_inst_addr_ok", 32'(inst_sram_addr_ok), 32'(e_ird));
      chk("m_data_addr_ok", 32'(data_sram_addr_ok), 32'(e_drd || e_dwr));
      chk("m_arvalid", 32'(arvalid), 32'(m_ar_v));
      if (m_ar_v) begin
        chk("m_araddr", araddr, m_araddr);
        chk("m_arid", 32'(arid), 32'(m_arid));
        chk("m_arsize", 32'(arsize), 32'(m_arsize));
      end
      chk("m_awvalid", 32'(awvalid), 32'(m_aw_v));
      chk("m_wvalid", 32'(wvalid), 32'(m_w_v));
      if (m_aw_v) begin
        chk("m_awaddr", awaddr, m_awaddr);
        chk("m_awsize", 32'(awsize), 32'(m_awsize));
        chk("m_awid", 32'(awid), 32'd1);
      end
      if (m_w_v) begin
        chk("m_wdata", wdata, m_wdata);
        chk("m_wstrb", 32'(wstrb), 32'(m_wstrb));
        chk("m_wlast", 32'(wlast), 32'd1);
        chk("m_wid", 32'(wid), 32'd1);
      end
      chk("m_inst_data_ok", 32'(inst_sram_data_ok), 32'(m_inst_ok));
      chk("m_data_data_ok", 32'(data_sram_data_ok), 32'(m_data_ok));
      chk("m_inst_rdata", inst_sram_rdata, m_inst_rd);
      chk("m_data_rdata", data_sram_rdata, m_data_rd);
      chk("m_rready", 32'(rready), 32'd1);
      chk("m_bready", 32'(bready), 32'd1);
    end
    if (reset) begin
      m_ar_v = 0; m_wr_busy = 0; m_aw_v = 0; m_w_v = 0;
      m_inst_out = 0; m_data_out = 0; m_inst_ok = 0; m_data_ok = 0;
      m_inst_rd = '0; m_data_rd = '0;
    end else begin
      if (m_ar_v && arready) m_ar_v = 0;
      if (e_drd) begin
        m_ar_v = 1; m_araddr = data_sram_addr; m_arid = 4'd1; m_arsize = {1'b0, data_sram_size};
      end else if (e_ird) begin
        m_ar_v = 1; m_araddr = inst_sram_addr; m_arid = 4'd0; m_arsize = {1'b0, inst_sram_size};
      end
      if (m_aw_v && awready) m_aw_v = 0;
      if (m_w_v && wready) m_w_v = 0;
      if (bvalid) m_wr_busy = 0;
      if (e_dwr) begin
        m_wr_busy = 1; m_aw_v = 1; m_w_v = 1;
        m_awaddr = data_sram_addr; m_awsize = {1'b0, data_sram_size};
        m_wdata = data_sram_wdata; m_wstrb = data_sram_wstrb;
      end
      m_inst_out = (m_inst_out && !r_i) || e_ird;
      m_data_out = (m_data_out && !r_d && !bvalid) || e_drd || e_dwr;
      m_inst_ok  = r_i;
      m_data_ok  = r_d || bvalid;
      if (r_i) m_inst_rd = rdata;
      if (r_d) m_data_rd = rdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  bit sl_rd_pend [2];
  bit sl_aw, sl_w, ireq_done, dreq_done;

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'hF;
    inst_sram_addr = '0; inst_sram_wdata = '0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 4'hF;
    data_sram_addr = '0; data_sram_wdata = '0;
    arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    smp;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_inst_rdata", inst_sram_rdata, 32'd0);
    chk("rst_rready", 32'(rready), 32'd1);
    chk("const_arburst", 32'(arburst), 32'd1);
    chk("const_awlen", 32'(awlen), 32'd0);

    // Inst read alone
    tick; inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2;
    smp; chk("d1_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    tick; inst_sram_req = 0;
    smp; chk("d1_arvalid", 32'(arvalid), 32'd1);
    chk("d1_araddr", araddr, 32'h1C00_0000);
    chk("d1_arid", 32'(arid), 32'd0);
    chk("d1_arsize", 32'(arsize), 32'd2);
    tick; arready = 1; smp;
    tick; arready = 0; smp; chk("d1_arvalid_drop", 32'(arvalid), 32'd0);
    tick; rvalid = 1; rid = 4'd0; rdata = 32'h0280_0C0C;
    smp; chk("d1_data_ok_early", 32'(inst_sram_data_ok), 32'd0);
    tick; rvalid = 0;
    smp; chk("d1_data_ok", 32'(inst_sram_data_ok), 32'd1);
    chk("d1_rdata", inst_sram_rdata, 32'h0280_0C0C);
    tick; smp; chk("d1_data_ok_pulse", 32'(inst_sram_data_ok), 32'd0);

    // Arbitration, then out-of-order return
    tick; inst_sram_req = 1; inst_sram_addr = 32'h1C00_0010;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1C00_1000; data_sram_size = 2'd2;
    smp; chk("d2_data_addr_ok", 32'(data_sram_addr_ok), 32'd1);
    chk("d2_inst_blocked", 32'(inst_sram_addr_ok), 32'd0);
    tick; data_sram_req = 0; arready = 1;
    smp; chk("d2_arid_data", 32'(arid), 32'd1);
    chk("d2_araddr_data", araddr, 32'h1C00_1000);
    chk("d2_inst_wait_ar", 32'(inst_sram_addr_ok), 32'd0);
    tick; arready = 0;
    smp; chk("d2_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    tick; inst_sram_req = 0; arready = 1;
    smp; chk("d2_arid_inst", 32'(arid), 32'd0);
    chk("d2_araddr_inst", araddr, 32'h1C00_0010);
    tick; arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'hDDDD_0001; smp;
    tick; rid = 4'd0; rdata = 32'h1111_0000;
    smp; chk("d3_data_ok_first", 32'(data_sram_data_ok), 32'd1);
    chk("d3_data_rdata", data_sram_rdata, 32'hDDDD_0001);
    chk("d3_inst_not_yet", 32'(inst_sram_data_ok), 32'd0);
    tick; rvalid = 0;
    smp; chk("d3_inst_ok", 32'(inst_sram_data_ok), 32'd1);
    chk("d3_inst_rdata", inst_sram_rdata, 32'h1111_0000);
    chk("d3_data_ok_pulse", 32'(data_sram_data_ok), 32'd0);

    // Store with delayed awready, inst read blocked until write completes
    tick; data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1C00_8000;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h1234_5678; wready = 1; awready = 0;
    smp; chk("d4_store_addr_ok", 32'(data_sram_addr_ok), 32'd1);
    tick; data_sram_req = 0; data_sram_wr = 0; inst_sram_req = 1; inst_sram_addr = 32'h1C00_0020;
    smp; chk("d4_awvalid", 32'(awvalid), 32'd1);
    chk("d4_wvalid", 32'(wvalid), 32'd1);
    chk("d4_awaddr", awaddr, 32'h1C00_8000);
    chk("d4_wdata", wdata, 32'h1234_5678);
    chk("d4_wstrb", 32'(wstrb), 32'h3);
    chk("d4_raw_block1", 32'(inst_sram_addr_ok), 32'd0);
    tick; wready = 0;
    smp; chk("d4_wvalid_drop", 32'(wvalid), 32'd0);
    chk("d4_awvalid_hold", 32'(awvalid), 32'd1);
    tick; awready = 1;
    smp; chk("d4_awvalid_hold3", 32'(awvalid), 32'd1);
    tick; awready = 0;
    smp; chk("d4_awvalid_drop", 32'(awvalid), 32'd0);
    chk("d4_raw_block2", 32'(inst_sram_addr_ok), 32'd0);
    tick; bvalid = 1; bid = 4'd1;
    smp; chk("d4_b_data_ok_early", 32'(data_sram_data_ok), 32'd0);
    chk("d4_raw_block3", 32'(inst_sram_addr_ok), 32'd0);
    tick; bvalid = 0;
    smp; chk("d4_b_data_ok", 32'(data_sram_data_ok), 32'd1);
    chk("d4_raw_release", 32'(inst_sram_addr_ok), 32'd1);
    tick; inst_sram_req = 0; arready = 1;
    smp; chk("d4_araddr", araddr, 32'h1C00_0020);
    tick; arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'hCAFE_0020; smp;
    tick; rvalid = 0;
    smp; chk("d4_inst_rdata", inst_sram_rdata, 32'hCAFE_0020);
    chk("d4_data_rdata_held", data_sram_rdata, 32'hDDDD_0001);

    // Reset while AR is pending
    tick; inst_sram_req = 1; inst_sram_addr = 32'h1C00_0040;
    smp; chk("d5_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    tick; inst_sram_req = 0;
    smp; chk("d5_arvalid", 32'(arvalid), 32'd1);
    tick; reset = 1; smp;
    tick; reset = 0; inst_sram_req = 1; inst_sram_addr = 32'h1C00_0050;
    smp; chk("d5_arvalid_clr", 32'(arvalid), 32'd0);
    chk("d5_reaccept", 32'(inst_sram_addr_ok), 32'd1);
    chk("d5_rdata_clr", inst_sram_rdata, 32'd0);
    tick; inst_sram_req = 0; arready = 1;
    smp; chk("d5_araddr", araddr, 32'h1C00_0050);
    tick; arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h5555_AAAA; smp;
    tick; rvalid = 0; smp;

    // Random traffic against a randomly stalling, out-of-order slave
    sl_rd_pend[0] = 0; sl_rd_pend[1] = 0; sl_aw = 0; sl_w = 0;
    ireq_done = 0; dreq_done = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (arvalid && arready) sl_rd_pend[arid[0]] = 1;
      if (awvalid && awready) sl_aw = 1;
      if (wvalid && wready) sl_w = 1;
      if (inst_sram_req && inst_sram_addr_ok) ireq_done = 1;
      if (data_sram_req && data_sram_addr_ok) dreq_done = 1;
      @(posedge clk);
      #1;
      arready = ($urandom_range(0, 1) == 1);
      awready = ($urandom_range(0, 2) == 0);
      wready  = ($urandom_range(0, 1) == 1);
      rvalid = 0;
      bvalid = 0;
      if ((sl_rd_pend[0] || sl_rd_pend[1]) && $urandom_range(0, 2) == 0) begin
        int k;
        if (sl_rd_pend[0] && sl_rd_pend[1]) k = int'($urandom_range(0, 1));
        else k = sl_rd_pend[1] ? 1 : 0;
        rvalid = 1; rid = 4'(k); rdata = $urandom; sl_rd_pend[k] = 0;
      end
      if (sl_aw && sl_w && $urandom_range(0, 1) == 0) begin
        bvalid = 1; bid = 4'd1; sl_aw = 0; sl_w = 0;
      end
      if (ireq_done) begin inst_sram_req = 0; ireq_done = 0; end
      if (dreq_done) begin data_sram_req = 0; dreq_done = 0; end
      if (!inst_sram_req && $urandom_range(0, 3) == 0) begin
        inst_sram_req = 1;
        inst_sram_addr = $urandom & 32'hFFFF_FFFC;
        inst_sram_size = 2'($urandom_range(0, 2));
      end
      if (!data_sram_req && $urandom_range(0, 3) == 0) begin
        data_sram_req = 1;
        data_sram_wr = ($urandom_range(0, 1) == 1);
        data_sram_addr = $urandom & 32'hFFFF_FFFC;
        data_sram_size = 2'($urandom_range(0, 2));
        data_sram_wstrb = 4'($urandom);
        data_sram_wdata = $urandom;
      end
    end

    tick; inst_sram_req = 0; data_sram_req = 0; rvalid = 0; bvalid = 0;
    repeat (10) tick;
    smp;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Sits directly below the CPU core. Converts the core's two sram-like ports (inst, data; req/addr_ok/data_ok) into one AXI3 master interface.
- Read arbitration gives data priority over inst. Each port may have at most one transaction outstanding.
- Reads are tagged by ARID. Writes are single-beat, with AW and W issued independently.

Parameters:
- INST_ID, 4'd0, ARID used for inst reads
- DATA_ID, 4'd1, ARID/AWID/WID used for data accesses

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  core inst request (wr always 0)
- inst_sram_addr_ok/data_ok  out  1/1  request accepted / read data valid
- inst_sram_rdata  out  32  read data
- data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  core data request
- data_sram_addr_ok/data_ok  out  1/1  accepted / completed (load data or store response)
- data_sram_rdata  out  32  load data
- arid/araddr/arsize/arvalid  out  4/32/3/1  AR channel; arready in 1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  R channel; rready out 1
- awid/awaddr/awsize/awvalid  out  4/32/3/1  AW channel; awready in 1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  W channel; wready in 1
- bid/bresp/bvalid  in  4/2/1  B channel; bready out 1
- arlen/awlen  out  8  const 0
- arburst/awburst  out  2  const 2'b01
- arlock/awlock  out  2  const 0
- arcache/awcache  out  4  const 0
- arprot/awprot  out  3  const 0

Behaviour:
- Reset (synchronous, active-high, one clock clk) clears all state. At reset:
  - arvalid=awvalid=wvalid=0
  - rready=bready=1
  - addr_ok=data_ok=0 on both ports
  - rdata outputs=0
  - pending flags clear
- Reset mid-transaction drops all state; the AXI slave is reset together with the bridge.
- Pending flags:
  - inst_pend is set on inst accept and cleared on R with rid==INST_ID.
  - data_pend is set on data accept and cleared on R with rid==DATA_ID or on B.
- Read FSM, states AR_IDLE and AR_REQ:
  - In AR_IDLE, a candidate is: data_sram_req&~data_sram_wr&~data_pend, else inst_sram_req&~inst_pend.
  - Data wins if both are candidates. The winner gets addr_ok=1 (combinational, same cycle).
  - araddr/arsize={1'b0,size}/arid are latched, then go to AR_REQ.
  - In AR_REQ, arvalid=1 with fields stable; on arready go to AR_IDLE. No new read is accepted in AR_REQ.
- Write FSM, states W_IDLE, W_SEND, W_RESP:
  - In W_IDLE, a data write is accepted when data_sram_req&data_sram_wr&~data_pend and the read FSM is not granting data this cycle. It gets addr_ok=1.
  - On accept, latch addr/size/wstrb/wdata, set awvalid=wvalid=1, go to W_SEND.
  - In W_SEND, awvalid drops on awready and wvalid drops on wready, independently and in either order or the same cycle. When both are done, go to W_RESP.
  - In W_RESP, on bvalid go to W_IDLE.
- Hazard: while the write FSM is not W_IDLE, inst and data reads are not accepted. This keeps RAW ordering and self-modifying code correct.
- Completion is registered, one cycle after the handshake:
  - R handshake → next cycle the matching port gets data_ok=1 for exactly 1 cycle, rdata=registered rdata.
  - B handshake → next cycle data_sram_data_ok=1.
  - rdata is held until the next completion.
- Simultaneous events:
  - R for inst and B in the same cycle: both data_ok pulses occur next cycle on their own ports.
  - R for DATA_ID and B in the same cycle cannot occur, because data has at most one outstanding transaction.
- rresp/bresp are ignored. rlast is assumed 1.
- data_ok has no backpressure; the core always accepts it.

Decomposition:
- Shared package holds:
  - AXI constants: BURST_INCR, LEN_SINGLE, CACHE/PROT/LOCK zero
  - INST_ID/DATA_ID defaults
  - read FSM state enum
  - write FSM state enum
- One natural sub-module: axi_wr_channel, which holds the write FSM, the AW/W done tracking and the B response.

Test Plan:
- Inst read alone: inst req addr=0x1C000000 → addr_ok same cycle; arvalid, araddr=0x1C000000, arid=0, arsize=2. R rid=0 rdata=0x02800C0C → inst_sram_data_ok one cycle later with rdata=0x02800C0C.
- Arbitration: inst and data reads requested in the same cycle → only data_sram_addr_ok=1, arid=1. Inst accepted after AR handshake.
- Out-of-order return: inst and data reads both outstanding; R rid=1 arrives before rid=0 → data_ok on data port first with correct data, then inst.
- Store: wr=1 addr=0x1C008000 wstrb=4'b0011 wdata=0x12345678. awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid after 3. bvalid → data_sram_data_ok next cycle.
- RAW block: store issued, then an inst read request during W_SEND/W_RESP → inst addr_ok stays 0 until W_IDLE, then accepted.
- Reset mid-AR_REQ: reset asserted for 1 cycle → arvalid=0, both pending flags clear; a new inst req is accepted the next cycle.
